// File: rtl/ysyx_2022040010_mem_arbiter.sv
// ysyx_2022040010_mem_arbiter: N-channel arbiter onto one SRAM port with address remap
// and an in-order tag pipeline that steers read data back to the issuing channel.
module ysyx_2022040010_mem_arbiter #(
   parameter int NCH = 2,
   parameter int AW = 64,
   parameter int DW = 64,
   parameter int RD_LAT = 1,
   parameter int RR_MODE = 0,
   parameter logic [AW-1:0] REMAP_BASE = AW'(64'h8000_0000),
   localparam int SW = DW / 8,
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_we,
   input  logic [NCH*SW-1:0] ch_wstrb,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_gnt,
   output logic [NCH-1:0]    ch_rvalid,
   output logic [DW-1:0]     ch_rdata,
   output logic              mem_e,
   output logic              mem_we,
   output logic [SW-1:0]     mem_wstrb,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy
);
   logic [NCH-1:0] gnt_d;
   logic [IW-1:0] win_d, idx, ptr_q;
   logic found_d, grant_d, issue_d, we_d;
   logic [SW-1:0] st_d;
   logic [AW-1:0] ad_d, rm_d;
   logic [DW-1:0] wd_d;
   logic mem_e_q, mem_we_q;
   logic [SW-1:0] mem_wstrb_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [RD_LAT:0] tv_q;
   logic [RD_LAT:0][IW-1:0] tid_q;

   function automatic logic [IW-1:0] cand(input int k, input logic [IW-1:0] p);
      return RR_MODE != 0 ? IW'((int'(p) + 1 + k) % NCH) : IW'(k);
   endfunction

   // Fixed mode scans from ch0; round-robin scans from the channel after the last winner.
   always_comb begin
      gnt_d = '0;
      win_d = '0;
      idx = '0;
      found_d = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         idx = cand(k, ptr_q);
         if (!found_d && ch_req[idx]) begin
            gnt_d[idx] = 1'b1;
            win_d = idx;
            found_d = 1'b1;
         end
      end
   end

   assign grant_d = found_d && rst;
   assign ch_gnt = grant_d ? gnt_d : '0;
   assign we_d = ch_we[win_d];
   assign st_d = ch_wstrb[win_d*SW +: SW];
   assign ad_d = ch_addr[win_d*AW +: AW];
   assign wd_d = ch_wdata[win_d*DW +: DW];
   assign rm_d = ad_d >= REMAP_BASE ? ad_d - REMAP_BASE : ad_d;
   // An all-zero-strobe write is acknowledged but never reaches memory.
   assign issue_d = grant_d && !(we_d && st_d == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_e_q <= 1'b0;
         mem_we_q <= 1'b0;
         mem_wstrb_q <= '0;
         mem_addr_q <= '0;
         mem_wdata_q <= '0;
         tv_q <= '0;
         tid_q <= '0;
         ptr_q <= IW'(NCH - 1);
      end else begin
         mem_e_q <= issue_d;
         mem_we_q <= issue_d && we_d;
         if (issue_d) begin
            mem_wstrb_q <= st_d;
            mem_addr_q <= rm_d;
            mem_wdata_q <= wd_d;
         end
         if (grant_d) ptr_q <= win_d;
         tv_q <= {tv_q[RD_LAT-1:0], issue_d && !we_d};
         tid_q <= {tid_q[RD_LAT-1:0], win_d};
      end
   end

   assign mem_e = mem_e_q;
   assign mem_we = mem_we_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_addr = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ch_rvalid = tv_q[RD_LAT] ? NCH'(1) << tid_q[RD_LAT] : '0;
   assign ch_rdata = mem_rdata;
   assign busy = |tv_q;
endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// tb_ysyx_2022040010_mem_arbiter: instance A (2ch fixed, RD_LAT=1) and B (4ch round-robin, RD_LAT=3)
// checked every cycle against a return-schedule model, plus directed literal expectations.
module tb_ysyx_2022040010_mem_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;

   logic rst_n [2];
   logic [3:0] req [2], we [2];
   logic [7:0] st [2][4];
   logic [63:0] ad [2][4], wd [2][4], mrd [2];

   logic [1:0] a_gnt, a_rv;
   logic [3:0] b_gnt, b_rv;
   logic [63:0] a_rdata, a_addr, a_wdata, b_rdata, b_addr, b_wdata;
   logic [7:0] a_strb, b_strb;
   logic a_e, a_we, a_busy, b_e, b_we, b_busy;

   ysyx_2022040010_mem_arbiter #(.NCH(2), .RD_LAT(1), .RR_MODE(0)) u_a (
      .clk(clk), .rst(rst_n[0]), .ch_req(req[0][1:0]), .ch_we(we[0][1:0]),
      .ch_wstrb({st[0][1], st[0][0]}), .ch_addr({ad[0][1], ad[0][0]}), .ch_wdata({wd[0][1], wd[0][0]}),
      .ch_gnt(a_gnt), .ch_rvalid(a_rv), .ch_rdata(a_rdata), .mem_e(a_e), .mem_we(a_we),
      .mem_wstrb(a_strb), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(mrd[0]), .busy(a_busy));

   ysyx_2022040010_mem_arbiter #(.NCH(4), .RD_LAT(3), .RR_MODE(1)) u_b (
      .clk(clk), .rst(rst_n[1]), .ch_req(req[1]), .ch_we(we[1]),
      .ch_wstrb({st[1][3], st[1][2], st[1][1], st[1][0]}),
      .ch_addr({ad[1][3], ad[1][2], ad[1][1], ad[1][0]}),
      .ch_wdata({wd[1][3], wd[1][2], wd[1][1], wd[1][0]}),
      .ch_gnt(b_gnt), .ch_rvalid(b_rv), .ch_rdata(b_rdata), .mem_e(b_e), .mem_we(b_we),
      .mem_wstrb(b_strb), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(mrd[1]), .busy(b_busy));

   logic [3:0] o_gnt [2], o_rv [2];
   logic o_e [2], o_we [2], o_busy [2];
   logic [7:0] o_st [2];
   logic [63:0] o_ad [2], o_wd [2], o_rd [2];
   assign o_gnt[0] = {2'b00, a_gnt};
   assign o_gnt[1] = b_gnt;
   assign o_rv[0] = {2'b00, a_rv};
   assign o_rv[1] = b_rv;
   assign o_e[0] = a_e;
   assign o_e[1] = b_e;
   assign o_we[0] = a_we;
   assign o_we[1] = b_we;
   assign o_busy[0] = a_busy;
   assign o_busy[1] = b_busy;
   assign o_st[0] = a_strb;
   assign o_st[1] = b_strb;
   assign o_ad[0] = a_addr;
   assign o_ad[1] = b_addr;
   assign o_wd[0] = a_wdata;
   assign o_wd[1] = b_wdata;
   assign o_rd[0] = a_rdata;
   assign o_rd[1] = b_rdata;

   // Model: expected memory port contents and a per-cycle schedule of read returns (channel+1, 0 = none).
   logic m_e [2], m_we [2];
   logic [7:0] m_st [2];
   logic [63:0] m_ad [2], m_wd [2];
   int ptr [2];
   int rv_ch [2][16];
   logic [63:0] rv_ad [2][16];
   logic [63:0] hist [2][16];

   function automatic int nc(input int i); return i == 0 ? 2 : 4; endfunction
   function automatic int lat(input int i); return i == 0 ? 1 : 3; endfunction
   function automatic logic [63:0] f(input logic [63:0] a); return {a[31:0] ^ 32'hA5A5_0000, a[31:0]}; endfunction
   function automatic logic [63:0] remap(input logic [63:0] a);
      return a >= 64'h8000_0000 ? a - 64'h8000_0000 : a;
   endfunction

   function automatic logic [3:0] exp_gnt(input int i);
      logic [3:0] r;
      r = req[i];
      if (!rst_n[i] || r == 4'd0) return 4'd0;
      if (i == 0) return r & (~r + 4'd1);
      for (int k = 1; k <= nc(i); k++) begin
         int c;
         c = (ptr[i] + k) % nc(i);
         if (r[c]) return 4'd1 << c;
      end
      return 4'd0;
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      for (int k = 0; k < 4; k++) if (g[k]) return k;
      return 0;
   endfunction

   function automatic logic any_pending(input int i);
      for (int k = 0; k < 16; k++) if (rv_ch[i][k] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [3:0] g;
         int c;
         g = exp_gnt(i);
         if (!rst_n[i]) begin
            m_e[i] = 1'b0; m_we[i] = 1'b0; m_st[i] = '0; m_ad[i] = '0; m_wd[i] = '0;
            ptr[i] = nc(i) - 1;
            for (int k = 0; k < 16; k++) rv_ch[i][k] = 0;
         end else begin
            rv_ch[i][cyc % 16] = 0;
            m_e[i] = 1'b0;
            m_we[i] = 1'b0;
            if (g != 4'd0) begin
               c = onehot_idx(g);
               ptr[i] = c;
               if (!(we[i][c] && st[i][c] == 8'd0)) begin
                  m_e[i] = 1'b1;
                  m_we[i] = we[i][c];
                  m_st[i] = st[i][c];
                  m_ad[i] = remap(ad[i][c]);
                  m_wd[i] = wd[i][c];
                  if (!we[i][c]) begin
                     rv_ch[i][(cyc + 1 + lat(i)) % 16] = c + 1;
                     rv_ad[i][(cyc + 1 + lat(i)) % 16] = remap(ad[i][c]);
                  end
               end
            end
         end
      end
      cyc++;
   end

   // Memory: returns f(address) for the read the DUT presented RD_LAT cycles earlier.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) mrd[i] = hist[i][(cyc + 16 - lat(i)) % 16];
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [3:0] er;
         int s;
         s = cyc % 16;
         er = (rst_n[i] && rv_ch[i][s] != 0) ? 4'd1 << (rv_ch[i][s] - 1) : 4'd0;
         chk($sformatf("gnt%0d", i), 64'(o_gnt[i]), 64'(exp_gnt(i)));
         chk($sformatf("rvalid%0d", i), 64'(o_rv[i]), 64'(er));
         chk($sformatf("mem_e%0d", i), 64'(o_e[i]), 64'(rst_n[i] && m_e[i]));
         chk($sformatf("mem_we%0d", i), 64'(o_we[i]), 64'(rst_n[i] && m_we[i]));
         chk($sformatf("mem_wstrb%0d", i), 64'(o_st[i]), rst_n[i] ? 64'(m_st[i]) : 64'd0);
         chk($sformatf("mem_addr%0d", i), o_ad[i], rst_n[i] ? m_ad[i] : 64'd0);
         chk($sformatf("mem_wdata%0d", i), o_wd[i], rst_n[i] ? m_wd[i] : 64'd0);
         chk($sformatf("busy%0d", i), 64'(o_busy[i]), 64'(rst_n[i] && any_pending(i)));
         if (er != 4'd0) chk($sformatf("rdata%0d", i), o_rd[i], f(rv_ad[i][s]));
         hist[i][s] = (o_e[i] && !o_we[i]) ? f(o_ad[i]) : 64'hBADB_AD00_0000_0000 | 64'(cyc);
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic at_neg(); @(negedge clk); endtask
   task automatic rd(input int i, input int c, input logic [63:0] a);
      req[i][c] = 1'b1; we[i][c] = 1'b0; ad[i][c] = a; st[i][c] = 8'hFF; wd[i][c] = 64'h5A5A_0000 + a;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; req[i] = '0; we[i] = '0; mrd[i] = '0;
         for (int k = 0; k < 4; k++) begin st[i][k] = '0; ad[i][k] = '0; wd[i][k] = '0; end
         for (int k = 0; k < 16; k++) begin hist[i][k] = '0; rv_ch[i][k] = 0; rv_ad[i][k] = '0; end
      end
      tick(); tick();
      at_neg();
      chk("rst_mem_e", 64'(a_e), 64'd0);
      chk("rst_busy", 64'(b_busy), 64'd0);
      tick();
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      // Remapped read on ch1, RD_LAT=1
      tick(); rd(0, 1, 64'h8000_1000);
      at_neg(); chk("t1_gnt", 64'(a_gnt), 64'h2);
      tick(); req[0] = '0;
      at_neg(); chk("t1_mem_e", 64'(a_e), 64'd1); chk("t1_mem_we", 64'(a_we), 64'd0); chk("t1_addr", a_addr, 64'h1000);
      tick();
      at_neg(); chk("t1_rvalid", 64'(a_rv), 64'h2); chk("t1_rdata", a_rdata, 64'hA5A5_1000_0000_1000);
      // Fixed priority: ch0 holds off ch1
      tick(); rd(0, 0, 64'h100); rd(0, 1, 64'h200);
      for (int k = 0; k < 3; k++) begin at_neg(); chk("t2_gnt_ch0", 64'(a_gnt), 64'h1); tick(); end
      req[0][0] = 1'b0;
      at_neg(); chk("t2_gnt_ch1", 64'(a_gnt), 64'h2);
      tick(); req[0] = '0;
      // Writes: partial strobe, then zero strobe
      tick(); req[0][0] = 1'b1; we[0][0] = 1'b1; st[0][0] = 8'h0F; ad[0][0] = 64'h8000_0008; wd[0][0] = 64'h1122_3344_5566_7788;
      at_neg(); chk("t5_gnt", 64'(a_gnt), 64'h1);
      tick(); req[0] = '0;
      at_neg(); chk("t5_we", 64'(a_we), 64'd1); chk("t5_strb", 64'(a_strb), 64'h0F); chk("t5_addr", a_addr, 64'h8);
      chk("t5_wdata", a_wdata, 64'h1122_3344_5566_7788);
      tick();
      at_neg(); chk("t5_no_rvalid", 64'(a_rv), 64'd0);
      tick(); req[0][0] = 1'b1; we[0][0] = 1'b1; st[0][0] = 8'h00;
      at_neg(); chk("t5z_gnt", 64'(a_gnt), 64'h1);
      tick(); req[0] = '0; we[0] = '0;
      at_neg(); chk("t5z_mem_e", 64'(a_e), 64'd0);
      // Round-robin rotation, remap boundary and pass-through
      tick();
      rd(1, 0, 64'h8000_0000); rd(1, 1, 64'h8000_0040); rd(1, 2, 64'h8000_0080); rd(1, 3, 64'h7FFF_FFF8);
      for (int k = 0; k < 5; k++) begin
         logic [3:0] e;
         e = k == 4 ? 4'h1 : 4'h1 << k;
         at_neg(); chk("t3_rr_gnt", 64'(b_gnt), 64'(e));
         if (k == 1) chk("t3_base_addr", b_addr, 64'h0);
         if (k == 4) chk("t3_pass_addr", b_addr, 64'h7FFF_FFF8);
         tick();
      end
      req[1] = '0;
      repeat (6) tick();
      // RD_LAT=3 in-order returns
      rd(1, 0, 64'h8000_0100);
      at_neg(); tick(); req[1] = '0; rd(1, 1, 64'h8000_0200);
      at_neg(); tick(); req[1] = '0; rd(1, 0, 64'h8000_0300);
      at_neg(); tick(); req[1] = '0;
      at_neg(); chk("t4_rv_t3", 64'(b_rv), 64'h0);
      tick(); at_neg(); chk("t4_rv_t4", 64'(b_rv), 64'h1); chk("t4_busy", 64'(b_busy), 64'd1);
      tick(); at_neg(); chk("t4_rv_t5", 64'(b_rv), 64'h2);
      tick(); at_neg(); chk("t4_rv_t6", 64'(b_rv), 64'h1);
      tick(); at_neg(); chk("t4_idle", 64'(b_busy), 64'd0);
      // Reset with a read in flight
      tick(); rd(1, 2, 64'h8000_0400);
      at_neg(); chk("t6_gnt", 64'(b_gnt), 64'h4);
      tick(); req[1] = '0; rst_n[1] = 1'b0;
      at_neg(); chk("t6_mem_e", 64'(b_e), 64'd0); chk("t6_busy", 64'(b_busy), 64'd0); chk("t6_rv", 64'(b_rv), 64'd0);
      tick(); tick(); rst_n[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin at_neg(); chk("t6_no_rv", 64'(b_rv), 64'd0); tick(); end
      rd(1, 0, 64'h10); rd(1, 1, 64'h20); rd(1, 2, 64'h30); rd(1, 3, 64'h40);
      at_neg(); chk("t6_gnt_ch0", 64'(b_gnt), 64'h1);
      tick(); req[1] = '0;
      repeat (6) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
